// File: rtl/alu_ex_stage.sv
// Registered 16-bit execute stage: ADD/SUB/XOR with signed saturation plus a
// four-lane saturating sub-word add, a one-entry output register and Z/V/N flags.

module alu_ex_lane #(
    parameter int VEC_W = 4
) (
    input  logic [VEC_W-1:0] a,
    input  logic [VEC_W-1:0] b,
    output logic [VEC_W-1:0] sum,
    output logic             sat
);
    logic [VEC_W:0] s;

    always_comb begin
        s   = {a[VEC_W-1], a} + {b[VEC_W-1], b};
        // Sign bits disagree only when the lane overflowed.
        sat = s[VEC_W] ^ s[VEC_W-1];
        sum = s[VEC_W-1:0];
        if (sat)
            sum = s[VEC_W] ? {1'b1, {(VEC_W-1){1'b0}}} : {1'b0, {(VEC_W-1){1'b1}}};
    end
endmodule

module alu_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  rd,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [3:0]  out_rd,
    output logic [3:0]  sat_mask,
    output logic [2:0]  flags
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 4;

    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_XOR = 2'b10, OP_PADDSB = 2'b11} op_e;

    typedef struct packed {
        logic [15:0]          result;
        logic [3:0]           rd;
        logic [NUM_LANES-1:0] sat_mask;
    } ex_rsp_t;

    logic                            accept;
    ex_rsp_t                         rsp_d, rsp_q;
    logic [2:0]                      flags_d, flags_q;
    logic                            vld_q;
    logic [16:0]                     wide;
    logic [15:0]                     as_res;
    logic                            as_sat;
    logic [15:0]                     xor_res;
    logic [NUM_LANES-1:0][VEC_W-1:0] a_lanes, b_lanes, p_lanes;
    logic [NUM_LANES-1:0]            p_sat;

    assign in_ready = !flush && (!vld_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign a_lanes = a;
    assign b_lanes = b;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        alu_ex_lane #(.VEC_W(VEC_W)) u_lane (
            .a   (a_lanes[i]),
            .b   (b_lanes[i]),
            .sum (p_lanes[i]),
            .sat (p_sat[i])
        );
    end

    always_comb begin
        if (op_e'(op) == OP_SUB)
            wide = {a[15], a} - {b[15], b};
        else
            wide = {a[15], a} + {b[15], b};
        as_sat  = wide[16] ^ wide[15];
        as_res  = as_sat ? (wide[16] ? 16'h8000 : 16'h7FFF) : wide[15:0];
        xor_res = a ^ b;
    end

    always_comb begin
        rsp_d.rd       = rd;
        rsp_d.result   = as_res;
        rsp_d.sat_mask = '0;
        flags_d        = {(as_res == 16'h0), as_sat, as_res[15]};
        case (op_e'(op))
            OP_XOR: begin
                rsp_d.result = xor_res;
                flags_d      = {(xor_res == 16'h0), flags_q[1:0]};
            end
            OP_PADDSB: begin
                rsp_d.result   = p_lanes;
                rsp_d.sat_mask = p_sat;
                flags_d        = flags_q;
            end
            default: ;
        endcase
    end

    // Flush outranks accept and drain; data registers only move on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            rsp_q   <= '0;
            flags_q <= 3'b000;
        end else if (flush) begin
            vld_q <= 1'b0;
        end else if (accept) begin
            vld_q   <= 1'b1;
            rsp_q   <= rsp_d;
            flags_q <= flags_d;
        end else if (out_ready) begin
            vld_q <= 1'b0;
        end
    end

    assign out_valid = vld_q;
    assign result    = rsp_q.result;
    assign out_rd    = rsp_q.rd;
    assign sat_mask  = rsp_q.sat_mask;
    assign flags     = flags_q;
endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: arithmetic/saturation vectors, flag rules,
// backpressure, flush and asynchronous reset mid-stall.

module tb_alu_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [3:0]  rd;
    logic        flush;
    logic        out_valid, out_ready;
    logic [15:0] result;
    logic [3:0]  out_rd, sat_mask;
    logic [2:0]  flags;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_ex_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .rd        (rd),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_rd    (out_rd),
        .sat_mask  (sat_mask),
        .flags     (flags)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One op with the output free to drain; sampled 1 time unit after the edge.
    task automatic send(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input logic [3:0] r);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y; rd = r; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; rd = '0;
        flush = 1'b0; out_ready = 1'b1;
        #12;
        check("rst out_valid", {15'b0, out_valid}, 16'h0);
        check("rst result", result, 16'h0000);
        check("rst out_rd", {12'b0, out_rd}, 16'h0);
        check("rst sat_mask", {12'b0, sat_mask}, 16'h0);
        check("rst flags", {13'b0, flags}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst in_ready", {15'b0, in_ready}, 16'h1);

        send(2'b00, 16'h7000, 16'h7000, 4'd1);
        check("add sat+ result", result, 16'h7FFF);
        check("add sat+ flags", {13'b0, flags}, 16'h2);
        check("add sat+ valid", {15'b0, out_valid}, 16'h1);
        check("add sat+ rd", {12'b0, out_rd}, 16'h1);

        send(2'b00, 16'h0003, 16'hFFFD, 4'd2);
        check("add zero result", result, 16'h0000);
        check("add zero flags", {13'b0, flags}, 16'h4);

        send(2'b01, 16'h8000, 16'h0001, 4'd3);
        check("sub sat- result", result, 16'h8000);
        check("sub sat- flags", {13'b0, flags}, 16'h3);

        send(2'b10, 16'h1234, 16'h1234, 4'd4);
        check("xor zero result", result, 16'h0000);
        check("xor zero flags", {13'b0, flags}, 16'h7);

        send(2'b11, 16'h7812, 16'h1F88, 4'd5);
        check("paddsb result", result, 16'h789A);
        check("paddsb mask", {12'b0, sat_mask}, 16'hC);
        check("paddsb flags", {13'b0, flags}, 16'h7);

        send(2'b11, 16'h0000, 16'h0000, 4'd6);
        check("paddsb0 result", result, 16'h0000);
        check("paddsb0 mask", {12'b0, sat_mask}, 16'h0);

        send(2'b10, 16'h00FF, 16'h0F0F, 4'd7);
        check("xor nz result", result, 16'h0FF0);
        check("xor nz flags", {13'b0, flags}, 16'h3);
        check("xor mask clr", {12'b0, sat_mask}, 16'h0);

        send(2'b00, 16'hFFFE, 16'h0001, 4'd8);
        check("add neg result", result, 16'hFFFF);
        check("add neg flags", {13'b0, flags}, 16'h1);

        // Let the stage drain before the backpressure sequence.
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain valid", {15'b0, out_valid}, 16'h0);

        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; a = 16'h0010; b = 16'h0020; rd = 4'd5; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("bp acc result", result, 16'h0030);
        check("bp acc flags", {13'b0, flags}, 16'h0);
        @(negedge clk);
        op = 2'b01; a = 16'h0100; b = 16'h0001; rd = 4'd6;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp in_ready", {15'b0, in_ready}, 16'h0);
            check("bp valid", {15'b0, out_valid}, 16'h1);
            check("bp result", result, 16'h0030);
            check("bp rd", {12'b0, out_rd}, 16'h5);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp comb ready", {15'b0, in_ready}, 16'h1);
        @(posedge clk);
        #1;
        check("bp 2nd result", result, 16'h00FF);
        check("bp 2nd rd", {12'b0, out_rd}, 16'h6);
        check("bp 2nd valid", {15'b0, out_valid}, 16'h1);

        // Flush while a result is held and a saturating op is presented.
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; a = 16'h8000; b = 16'h8000; rd = 4'd7;
        out_ready = 1'b0; flush = 1'b1;
        #1;
        check("flush in_ready", {15'b0, in_ready}, 16'h0);
        @(posedge clk);
        #1;
        check("flush valid", {15'b0, out_valid}, 16'h0);
        check("flush flags", {13'b0, flags}, 16'h0);
        check("flush rd", {12'b0, out_rd}, 16'h6);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;

        // Asynchronous reset between edges during a stall.
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; a = 16'hFFFF; b = 16'hFFFF; rd = 4'd9; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("stall result", result, 16'hFFFE);
        check("stall flags", {13'b0, flags}, 16'h1);
        a = 16'h0001; b = 16'h0001; rd = 4'd3;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst valid", {15'b0, out_valid}, 16'h0);
        check("async rst result", result, 16'h0000);
        check("async rst rd", {12'b0, out_rd}, 16'h0);
        check("async rst flags", {13'b0, flags}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;

        send(2'b00, 16'h0001, 16'h0001, 4'd3);
        check("post rst result", result, 16'h0002);
        check("post rst valid", {15'b0, out_valid}, 16'h1);
        check("post rst rd", {12'b0, out_rd}, 16'h3);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
